// File: rtl/sa_mm_engine_if.sv
// Systolic-array matmul handshake between the attention controller (master)
// and the SA engine (slave). Operands are flattened packed arrays indexed
// [row][col] with each element D_W bits wide.
interface sa_mm_engine_if #(
  parameter int D_W   = 8,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int K_MAX = 128
);
  logic                                     I_SA_START;
  logic [0:SA_R-1][0:K_MAX-1][D_W-1:0]      I_MAT_1;
  logic [0:K_MAX-1][0:SA_C-1][D_W-1:0]      I_MAT_2;
  logic [7:0]                               I_M_DIM;
  logic                                     O_PE_SHIFT;
  logic                                     O_SA_VLD;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]       O_SA_RESULT;

  modport master (
    output I_SA_START, I_MAT_1, I_MAT_2, I_M_DIM,
    input  O_PE_SHIFT, O_SA_VLD, O_SA_RESULT
  );

  modport slave (
    input  I_SA_START, I_MAT_1, I_MAT_2, I_M_DIM,
    output O_PE_SHIFT, O_SA_VLD, O_SA_RESULT
  );
endinterface

// File: rtl/sa_mm_engine.sv
// Output-stationary SA_R x SA_C systolic matmul engine (responder side).
// Row i of A enters column 0 with skew i and travels right; column j of B
// enters row 0 with skew j and travels down; each PE accumulates locally.
// Build option: define SA_ROUND_EN to round half up before the >>> FRAC
// quantization; otherwise the result truncates toward minus infinity.
module sa_mm_engine #(
  parameter int D_W   = 8,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int K_MAX = 128,
  parameter int FRAC  = 5,
  parameter int ACC_W = 24
) (
  input  logic          I_CLK,
  input  logic          I_ASYN_RSTN,
  input  logic          I_SYNC_RSTN,
  sa_mm_engine_if.slave bus
);
  localparam int K_W  = $clog2(K_MAX);
  localparam int SKEW = SA_R + SA_C - 2;
  localparam int T_W  = $clog2(K_MAX + SKEW + 1);
  localparam int AW1  = ACC_W + 1;
  localparam logic signed [ACC_W:0] SAT_HI = AW1'((2 ** (D_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = AW1'(-(2 ** (D_W - 1)));
`ifdef SA_ROUND_EN
  localparam logic signed [ACC_W:0] RND = AW1'(2 ** (FRAC - 1));
`else
  localparam logic signed [ACC_W:0] RND = '0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                          state_q, state_d;
  logic [T_W-1:0]                      t_q, t_d;
  logic [7:0]                          mdim_q, mdim_d;
  logic [SA_R-1:0][SA_C-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [SA_R-1:0][SA_C-2:0][D_W-1:0]  a_q, a_d;
  logic [SA_R-2:0][SA_C-1:0][D_W-1:0]  b_q, b_d;
  logic                                vld_q, vld_d;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]  res_q, res_d;

  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]  a_in, b_in;
  logic signed [2*D_W-1:0]             prod [SA_R][SA_C];
  logic                                run;

  assign run = (state_q == ST_RUN);

  // Quantize one accumulator: optional rounding, arithmetic shift, saturate.
  function automatic logic [D_W-1:0] quantize(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W:0] shifted;
    shifted = ($signed({acc[ACC_W-1], acc}) + RND) >>> FRAC;
    if (shifted > SAT_HI)      quantize = D_W'(SAT_HI);
    else if (shifted < SAT_LO) quantize = D_W'(SAT_LO);
    else                       quantize = D_W'(shifted);
  endfunction

  // Operand feed at the array edges, neighbour forwarding inside, PE products.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < SA_R; i++) begin
      if (run && int'(t_q) >= i && int'(t_q) - i < int'(mdim_q))
        a_in[i][0] = bus.I_MAT_1[i][K_W'(int'(t_q) - i)];
      for (int j = 1; j < SA_C; j++) a_in[i][j] = a_q[i][j-1];
    end
    for (int j = 0; j < SA_C; j++) begin
      if (run && int'(t_q) >= j && int'(t_q) - j < int'(mdim_q))
        b_in[0][j] = bus.I_MAT_2[K_W'(int'(t_q) - j)][j];
      for (int i = 1; i < SA_R; i++) b_in[i][j] = b_q[i-1][j];
    end
    for (int i = 0; i < SA_R; i++)
      for (int j = 0; j < SA_C; j++)
        prod[i][j] = $signed(a_in[i][j]) * $signed(b_in[i][j]);
  end

  // Sequencing: IDLE -> RUN for Mdim+SKEW cycles -> DONE (capture result) -> IDLE.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    mdim_d  = mdim_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = 1'b0;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_SA_START) begin
          state_d = ST_RUN;
          t_d     = '0;
          mdim_d  = (int'(bus.I_M_DIM) > K_MAX) ? 8'(K_MAX) : bus.I_M_DIM;
          acc_d   = '0;
          a_d     = '0;
          b_d     = '0;
        end
      end
      ST_RUN: begin
        t_d = t_q + 1'b1;
        for (int i = 0; i < SA_R; i++)
          for (int j = 0; j < SA_C; j++)
            acc_d[i][j] = acc_q[i][j] + ACC_W'(prod[i][j]);
        for (int i = 0; i < SA_R; i++)
          for (int j = 0; j < SA_C - 1; j++) a_d[i][j] = a_in[i][j];
        for (int i = 0; i < SA_R - 1; i++)
          for (int j = 0; j < SA_C; j++) b_d[i][j] = b_in[i][j];
        if (int'(t_q) == int'(mdim_q) + SKEW - 1) state_d = ST_DONE;
      end
      ST_DONE: begin
        vld_d   = 1'b1;
        state_d = ST_IDLE;
        for (int i = 0; i < SA_R; i++)
          for (int j = 0; j < SA_C; j++) res_d[i][j] = quantize(acc_q[i][j]);
      end
      default: state_d = ST_IDLE;
    endcase
    if (!I_SYNC_RSTN) begin
      state_d = ST_IDLE;
      t_d     = '0;
      mdim_d  = '0;
      acc_d   = '0;
      a_d     = '0;
      b_d     = '0;
      vld_d   = 1'b0;
      res_d   = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      mdim_q  <= '0;
      // NOTE: the accumulator array is reset (not left as uninitialised storage) because an aborted run must read back as zero.
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
      state_q <= state_d;
      t_q     <= t_d;
      mdim_q  <= mdim_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
    end
  end

  assign bus.O_PE_SHIFT  = run;
  assign bus.O_SA_VLD    = vld_q;
  assign bus.O_SA_RESULT = res_q;
endmodule
